fifo_rd_ctrl: RTL and testbench

Read-domain controller of the dual-clock FIFO: the reader that mirrors the write-side pointer logic. It consumes the write pointer after it has crossed into the read clock through `ff_2_sync`. It maintains the binary and Gray read pointers, detects empty, issues reads to the synchronous dual-port RAM, and presents data to the consumer through a valid/ready interface with a 2-entry output buffer, sustaining one word per cycle.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 59 +++++
 rtl/fifo_rd_ctrl.sv | 92 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and Gray-code helpers for the read and write controllers.
package fifo_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer of the FIFO read side: head register plus skid register.
module fifo_rd_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_land,
  input  logic [DATA_W-1:0] i_land_data,
  input  logic              i_pop,
  output logic [1:0]        o_occ,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] r_head, r_skid;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] w_head_nxt, w_skid_nxt;
  logic [1:0]        w_occ_nxt;

  // Landing goes to the head whenever the head is free after this cycle's pop.
  always_comb begin
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    w_occ_nxt  = r_occ;
    if (i_pop) begin
      if (r_occ == 2'd2) begin
        w_head_nxt = r_skid;
        if (i_land) w_skid_nxt = i_land_data;
        else        w_occ_nxt  = 2'd1;
      end else begin
        if (i_land) w_head_nxt = i_land_data;
        else        w_occ_nxt  = 2'd0;
      end
    end else if (i_land) begin
      if (r_occ == 2'd0) begin
        w_head_nxt = i_land_data;
        w_occ_nxt  = 2'd1;
      end else begin
        w_skid_nxt = i_land_data;
        w_occ_nxt  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
      r_occ  <= 2'd0;
    end else begin
      r_head <= w_head_nxt;
      r_skid <= w_skid_nxt;
      r_occ  <= w_occ_nxt;
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_head;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: pointers, empty/level, RAM read issue.
// Optional FIFO_RD_ALMOST_EMPTY_EN adds AE_THRESH and a registered almost_empty output.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int AE_THRESH = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [DATA_W-1:0] rdata_mem,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   rd_level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic              almost_empty
`endif
);
  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] r_rptr_bin, r_rptr_gray;
  logic [PTR_W-1:0] w_rptr_bin_nxt, w_wptr_bin;
  logic             r_infl;
  logic [1:0]       w_occ;
  logic             w_pop, w_ren;
  logic [2:0]       w_need;

  assign w_wptr_bin     = PTR_W'(gray2bin(32'(wptr_gray_sync)));
  assign w_rptr_bin_nxt = r_rptr_bin + 1'b1;
  assign empty          = (r_rptr_gray == wptr_gray_sync);
  assign rd_level       = w_wptr_bin - r_rptr_bin;

  // Words held plus words in flight after this cycle's pop must stay below 2.
  assign w_pop  = rd_valid & rd_ready;
  assign w_need = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_ren  = !empty && (w_need < 3'd2);

  assign ren       = w_ren;
  assign raddr     = r_rptr_bin[ADDR_W-1:0];
  assign rptr_gray = r_rptr_gray;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr_bin  <= '0;
      r_rptr_gray <= '0;
      r_infl      <= 1'b0;
    end else begin
      r_infl <= w_ren;
      if (w_ren) begin
        r_rptr_bin  <= w_rptr_bin_nxt;
        r_rptr_gray <= PTR_W'(bin2gray(32'(w_rptr_bin_nxt)));
      end
    end
  end

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_land      (r_infl),
    .i_land_data (rdata_mem),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_valid     (rd_valid),
    .o_data      (rd_data)
  );

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [PTR_W+1:0] w_ae_sum;
  logic             r_almost_empty;

  // Counts every word the consumer can still get: in RAM, in flight and buffered.
  assign w_ae_sum = {2'b00, rd_level} + {{PTR_W{1'b0}}, w_occ} + {{(PTR_W+1){1'b0}}, r_infl};

  always_ff @(posedge clk) begin
    if (rst) r_almost_empty <= 1'b1;
    else     r_almost_empty <= (w_ae_sum <= (PTR_W+2)'(AE_THRESH));
  end

  assign almost_empty = r_almost_empty;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed cases plus randomized traffic vs a queue model.
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW:0]   wptr_gray_sync = '0;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] rdata_mem = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [AW:0]   rd_level;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          almost_empty;
`endif

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wptr_gray_sync (wptr_gray_sync),
    .rptr_gray      (rptr_gray),
    .raddr          (raddr),
    .ren            (ren),
    .rdata_mem      (rdata_mem),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .empty          (empty),
    .rd_level       (rd_level)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .almost_empty   (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (ren === 1'b1) rdata_mem <= mem[raddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words written but not yet delivered, in order; pointers as plain counters.
  logic [DW-1:0] q[$];
  logic [AW:0]   wbin   = '0;
  logic [AW:0]   rptr_m = '0;
  int            issued = 0;
  int            popped = 0;
  bit            infl_m = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    int occ_m;
    bit exp_valid, exp_empty, exp_pop, exp_ren;
    if (rst) begin
      q.delete();
      rptr_m = '0;
      issued = 0;
      popped = 0;
      infl_m = 1'b0;
      hold_prev = 1'b0;
    end else begin
      occ_m     = issued - popped - int'(infl_m);
      exp_valid = (occ_m >= 1);
      exp_empty = (wbin == rptr_m);
      exp_pop   = exp_valid && rd_ready;
      exp_ren   = !exp_empty && ((occ_m + int'(infl_m) - int'(exp_pop)) < 2);
      chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
      chk("empty", 32'(empty), 32'(exp_empty));
      chk("ren", 32'(ren), 32'(exp_ren));
      chk("raddr", 32'(raddr), 32'(rptr_m[AW-1:0]));
      chk("rptr_gray", 32'(rptr_gray), 32'(rptr_m ^ (rptr_m >> 1)));
      chk("rd_level", 32'(rd_level), 32'(5'(wbin - rptr_m)));
      if (hold_prev && rd_valid) chk("rd_data_hold", 32'(rd_data), 32'(prev_data));
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_underflow: got word 0x%0h, expected no word at %0t", rd_data, $time);
        end else begin
          chk("order", 32'(rd_data), 32'(q[0]));
          q.pop_front();
        end
        popped++;
      end
      hold_prev = rd_valid && !rd_ready;
      prev_data = rd_data;
      if (ren) begin
        issued++;
        rptr_m = rptr_m + 1'b1;
      end
      infl_m = ren;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    q.push_back(d);
    wbin = wbin + 1'b1;
    wptr_gray_sync = wbin ^ (wbin >> 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rd_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (q.size() != 0 && n < budget);
    chk("drain_left", 32'(q.size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    int ren_tot, ren_run, ren_max, v_tot, v_run, v_max, p;
    int probs [4] = '{100, 50, 10, 85};
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("rst_level", 32'(rd_level), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);

    // Single word
    step();
    rst = 1'b0;
    put(8'hA5);
    rd_ready = 1'b1;
    @(negedge clk);
    chk("sw_ren", 32'(ren), 32'd1);
    chk("sw_raddr", 32'(raddr), 32'd0);
    @(negedge clk);
    chk("sw_empty", 32'(empty), 32'd1);
    chk("sw_rptr_gray", 32'(rptr_gray), 32'b00001);
    @(negedge clk);
    chk("sw_valid", 32'(rd_valid), 32'd1);
    chk("sw_data", 32'(rd_data), 32'hA5);

    // Streaming 8 words
    step();
    for (int i = 0; i < 8; i++) put(8'(8'h10 + i));
    ren_tot = 0; ren_run = 0; ren_max = 0; v_tot = 0; v_run = 0; v_max = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ren) begin ren_tot++; ren_run++; end else ren_run = 0;
      if (rd_valid) begin v_tot++; v_run++; end else v_run = 0;
      if (ren_run > ren_max) ren_max = ren_run;
      if (v_run > v_max) v_max = v_run;
    end
    chk("st_ren_total", 32'(ren_tot), 32'd8);
    chk("st_ren_run", 32'(ren_max), 32'd8);
    chk("st_valid_total", 32'(v_tot), 32'd8);
    chk("st_valid_run", 32'(v_max), 32'd8);

    // Backpressure
    step();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(8'(8'h20 + i));
    ren_tot = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ren) ren_tot++;
    end
    chk("bp_reads", 32'(ren_tot), 32'd2);
    chk("bp_ren_idle", 32'(ren), 32'd0);
    chk("bp_valid", 32'(rd_valid), 32'd1);
    chk("bp_head", 32'(rd_data), 32'h20);
    step();
    drain(40);

    // Wrap-around: bring the read pointer to 30, then write up to 34 (mod 32 = 2)
    for (int i = 0; i < 17; i++) begin
      put(8'(8'h40 + i));
      step();
    end
    drain(60);
    @(negedge clk);
    chk("wr_rptr30", 32'(rptr_gray), 32'b10001);
    step();
    for (int i = 0; i < 4; i++) put(8'(8'h60 + i));
    chk("wr_wptr_gray", 32'(wptr_gray_sync), 32'b00011);
    @(negedge clk);
    chk("wr_level", 32'(rd_level), 32'd4);
    chk("wr_raddr0", 32'(raddr), 32'd14);
    @(negedge clk);
    chk("wr_raddr1", 32'(raddr), 32'd15);
    @(negedge clk);
    chk("wr_raddr2", 32'(raddr), 32'd0);
    @(negedge clk);
    chk("wr_raddr3", 32'(raddr), 32'd1);
    step();
    drain(40);
    @(negedge clk);
    chk("wr_rptr_end", 32'(rptr_gray), 32'b00011);
    chk("wr_empty_end", 32'(empty), 32'd1);

    // Reset mid-stream with a word buffered and a read in flight
    step();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) put(8'(8'h70 + i));
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    rst = 1'b1;
    wbin = '0;
    wptr_gray_sync = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", 32'(rd_valid), 32'd0);
    chk("mr_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_ren", 32'(ren), 32'd0);

    // Randomized traffic with varying backpressure and occasional resets
    step();
    p = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) p = probs[(c / 250) % 4];
      rd_ready = ($urandom_range(0, 99) < p);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        wbin = '0;
        wptr_gray_sync = '0;
      end else if ($urandom_range(0, 99) < 45 && 5'(wbin - rptr_m) < 5'd16) begin
        put(8'($urandom_range(0, 255)));
      end
      step();
    end
    rst = 1'b0;
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
